// File: rtl/eth_tx_arbiter.sv
// ============================================================================
// Module   : eth_tx_arbiter
// Purpose  : Packet-granular round-robin arbiter sharing the Ethernet TX
//            AXI-Stream path, with a programmable inter-frame idle gap and
//            a forwarded-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package framing_synth_pkg;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tstrb;
        logic [7:0]  tkeep;
        logic        tlast;
        logic [3:0]  tid;
        logic [3:0]  tdest;
        logic [0:0]  tuser;
        logic        tvalid;
    } s_req_t;

    typedef struct packed {
        logic tready;
    } s_rsp_t;

endpackage

module eth_tx_arbiter #(
    parameter int unsigned NumIn    = 2,
    parameter type         axi_stream_req_t = framing_synth_pkg::s_req_t,
    parameter type         axi_stream_rsp_t = framing_synth_pkg::s_rsp_t,
    parameter int unsigned GapWidth = 8,
    parameter int unsigned CntWidth = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  axi_stream_req_t             in_req_i [NumIn],
    output axi_stream_rsp_t             in_rsp_o [NumIn],
    output axi_stream_req_t             out_req_o,
    input  axi_stream_rsp_t             out_rsp_i,
    input  logic                        en_i,
    input  logic [GapWidth-1:0]         gap_cycles_i,
    output logic                        busy_o,
    output logic [$clog2(NumIn)-1:0]    grant_o,
    output logic [CntWidth-1:0]         frame_cnt_o
);

    localparam int unsigned IdxWidth = $clog2(NumIn);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    state_e                 state_q,     state_d;
    logic [IdxWidth-1:0]    gnt_q,       gnt_d;
    logic [IdxWidth-1:0]    rr_q,        rr_d;
    logic [GapWidth-1:0]    gap_q,       gap_d;
    logic [CntWidth-1:0]    frame_cnt_q, frame_cnt_d;

    logic                   w_pick_valid;
    logic [IdxWidth-1:0]    w_pick_idx;
    logic [IdxWidth:0]      w_cand;
    logic [IdxWidth-1:0]    w_rr_next;
    logic                   w_last_hs;

    // Search rr_q, rr_q+1, ... modulo NumIn; one extra bit keeps the sum
    // from overflowing before the single wrap-around subtraction.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            w_cand = {1'b0, rr_q} + (IdxWidth+1)'(k);
            if (w_cand >= (IdxWidth+1)'(NumIn)) begin
                w_cand = w_cand - (IdxWidth+1)'(NumIn);
            end
            if (!w_pick_valid && in_req_i[w_cand[IdxWidth-1:0]].tvalid) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand[IdxWidth-1:0];
            end
        end
    end

    assign w_rr_next = (gnt_q == IdxWidth'(NumIn - 1)) ? '0 : gnt_q + 1'b1;

    assign w_last_hs = in_req_i[gnt_q].tvalid && in_req_i[gnt_q].tlast &&
                       out_rsp_i.tready;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        out_req_o   = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            in_rsp_o[k] = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i && w_pick_valid) begin
                    gnt_d   = w_pick_idx;
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                // Beats pass straight through; the grant is only released on
                // the tlast handshake so frames can never interleave.
                out_req_o              = in_req_i[gnt_q];
                in_rsp_o[gnt_q].tready = out_rsp_i.tready;
                if (w_last_hs) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    rr_d        = w_rr_next;
                    if (gap_cycles_i == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = gap_cycles_i;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GapWidth'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rr_q        <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = gnt_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
// ============================================================================
// Module   : tb_eth_tx_arbiter
// Purpose  : Scoreboard bench for eth_tx_arbiter; frame order comes from a
//            queue-based round-robin model, beats are checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_eth_tx_arbiter;
    import framing_synth_pkg::*;

    localparam int NUM = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  src;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    s_req_t      in_req [NUM];
    s_rsp_t      in_rsp [NUM];
    s_req_t      out_req;
    s_rsp_t      out_rsp;
    logic        en;
    logic [7:0]  gap;
    logic        busy;
    logic [0:0]  grant;
    logic [31:0] fcnt;

    always #4 clk = ~clk;

    eth_tx_arbiter #(
        .NumIn    (NUM),
        .GapWidth (8),
        .CntWidth (32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_req_i     (in_req),
        .in_rsp_o     (in_rsp),
        .out_req_o    (out_req),
        .out_rsp_i    (out_rsp),
        .en_i         (en),
        .gap_cycles_i (gap),
        .busy_o       (busy),
        .grant_o      (grant),
        .frame_cnt_o  (fcnt)
    );

    beat_t src_q [NUM][$];   // beats still to be offered by each source
    beat_t m_q   [NUM][$];   // beats not yet placed in the expected order
    beat_t exp_q [$];        // expected output beat order
    int    bub [NUM];
    int    total = 0;
    int    bad   = 0;
    int    model_rr = 0;
    int    frames_exp = 0;
    int    cyc = 0;
    int    hs_cnt = 0;
    int    last_tl = -1;
    int    last_gap = 0;
    bit    first_pending = 1'b0;
    bit    gap_chk = 1'b0;
    bit    sb_off = 1'b0;
    bit    gap_rand = 1'b0;
    int    rdy_mode = 0;     // 0: always ready, 1: random, 2: toggle
    int    bub_mode = 0;     // 0: none, 1: random 0..3, 2: always 3

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < NUM; s++) begin
            in_req[s] = '0;
            if (src_q[s].size() > 0 && bub[s] == 0) begin
                in_req[s].tdata  = src_q[s][0].data;
                in_req[s].tkeep  = src_q[s][0].keep;
                in_req[s].tstrb  = src_q[s][0].keep;
                in_req[s].tlast  = src_q[s][0].last;
                in_req[s].tid    = src_q[s][0].src;
                in_req[s].tdest  = 4'(s);
                in_req[s].tvalid = 1'b1;
            end
        end
    endtask

    // Handshakes are sampled on the falling edge, inputs change 1ns after the rise.
    task automatic step();
        bit    hs [NUM];
        beat_t b;
        @(negedge clk);
        for (int s = 0; s < NUM; s++) hs[s] = in_req[s].tvalid && in_rsp[s].tready;
        @(posedge clk);
        #1;
        for (int s = 0; s < NUM; s++) begin
            if (hs[s] && src_q[s].size() > 0) begin
                b = src_q[s].pop_front();
                if (b.last || bub_mode == 0) bub[s] = 0;
                else if (bub_mode == 1)      bub[s] = int'($urandom_range(0, 3));
                else                         bub[s] = 3;
            end else if (bub[s] > 0) begin
                bub[s]--;
            end
        end
        case (rdy_mode)
            1:       out_rsp.tready = ($urandom_range(0, 99) < 65);
            2:       out_rsp.tready = ~out_rsp.tready;
            default: out_rsp.tready = 1'b1;
        endcase
        if (gap_rand) gap = 8'($urandom_range(0, 4));
        drive_inputs();
    endtask

    task automatic gen_frame(input int s, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.last = (i == n - 1);
            b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.src  = 4'(s);
            src_q[s].push_back(b);
            m_q[s].push_back(b);
        end
    endtask

    // Reference arbitration: next requester with a pending frame, starting at the pointer.
    task automatic model_arb(input int n);
        int    pick;
        int    c;
        beat_t b;
        for (int f = 0; f < n; f++) begin
            pick = -1;
            for (int k = 0; k < NUM; k++) begin
                c = (model_rr + k) % NUM;
                if (pick < 0 && m_q[c].size() > 0) pick = c;
            end
            if (pick >= 0) begin
                do begin
                    b = m_q[pick].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                model_rr = (pick + 1) % NUM;
                frames_exp++;
            end
        end
    endtask

    task automatic load(input int nfr, input int minb, input int maxb, input int narb);
        for (int s = 0; s < NUM; s++)
            for (int f = 0; f < nfr; f++) gen_frame(s, int'($urandom_range(minb, maxb)));
        drive_inputs();
        last_tl       = -1;
        first_pending = 1'b0;
        model_arb(narb);
    endtask

    task automatic drain(input string nm, input int maxc, input int settle);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            step();
            n++;
        end
        chk({"drain_", nm}, exp_q.size(), 0);
        repeat (settle) step();
    endtask

    initial begin : monitor
        beat_t e;
        bit    allowed;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (out_req.tvalid && out_rsp.tready) hs_cnt++;
                if (!sb_off) begin
                    for (int k = 0; k < NUM; k++) begin
                        if (in_rsp[k].tready) begin
                            allowed = (exp_q.size() > 0) && (int'(exp_q[0].src) == k);
                            chk($sformatf("tready_owner%0d", k), allowed, 1);
                        end
                    end
                    if (out_req.tvalid) begin
                        chk("busy_while_valid", busy, 1);
                        if (first_pending && gap_chk && last_tl >= 0)
                            chk("gap_spacing", cyc - last_tl, last_gap + 2);
                        first_pending = 1'b0;
                        if (out_rsp.tready) begin
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_beat: got data %h, required no beat", out_req.tdata);
                            end else begin
                                e = exp_q.pop_front();
                                chk("beat_data", out_req.tdata, e.data);
                                chk("beat_last", out_req.tlast, e.last);
                                chk("beat_keep", out_req.tkeep, e.keep);
                                chk("beat_tid",  out_req.tid,   e.src);
                                chk("beat_grant", grant, e.src);
                                chk("src_tready", in_rsp[e.src[0]].tready, 1);
                            end
                            if (out_req.tlast) begin
                                first_pending = 1'b1;
                                last_tl       = cyc;
                                last_gap      = int'(gap);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int h0;
        int n;
        rst = 1'b1;
        en  = 1'b0;
        gap = 8'd0;
        out_rsp = '0;
        for (int s = 0; s < NUM; s++) begin
            in_req[s] = '0;
            bub[s]    = 0;
        end
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_out_zero", out_req == '0, 1);
        chk("rst_tready0", in_rsp[0].tready, 0);
        chk("rst_tready1", in_rsp[1].tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_fcnt", fcnt, 0);

        // Single requester, 3-beat frame, one-cycle grant latency.
        gen_frame(0, 3);
        drive_inputs();
        model_arb(1);
        en = 1'b1;
        #1;
        chk("lat_idle", out_req.tvalid, 0);
        step();
        #1;
        chk("lat_first", out_req.tvalid, 1);
        drain("single", 50, 4);
        chk("single_fcnt", fcnt, frames_exp);
        chk("single_grant", grant, 0);

        // Both requesters continuously valid, 2-beat frames, no gap.
        gap_chk = 1'b1;
        load(2, 2, 2, 2 * NUM);
        drain("rr", 200, 4);
        chk("rr_fcnt", fcnt, frames_exp);

        // Twelve-cycle inter-frame gap.
        gap = 8'd12;
        load(2, 1, 3, 2 * NUM);
        drain("gap12", 400, 16);
        chk("gap12_fcnt", fcnt, frames_exp);

        // Toggling downstream ready with 3-cycle source bubbles mid-frame.
        gap      = 8'd1;
        rdy_mode = 2;
        bub_mode = 2;
        load(1, 4, 4, NUM);
        drain("bp", 400, 4);
        chk("bp_fcnt", fcnt, frames_exp);

        // Random ready, bubbles and per-cycle gap changes.
        rdy_mode = 1;
        bub_mode = 1;
        gap_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            load(int'($urandom_range(2, 4)), 1, 5, 100);
            drain("rand", 3000, 8);
            chk("rand_fcnt", fcnt, frames_exp);
        end
        gap_rand = 1'b0;
        gap      = 8'd0;
        rdy_mode = 0;
        bub_mode = 0;
        repeat (8) step();

        // Enable low: requests pend without any grant.
        en = 1'b0;
        load(1, 2, 2, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            chk("en_low_valid", out_req.tvalid, 0);
            chk("en_low_busy", busy, 0);
            chk("en_low_tready", in_rsp[0].tready | in_rsp[1].tready, 0);
        end
        en = 1'b1;
        model_arb(NUM);
        drain("en_resume", 200, 4);

        // Enable dropped mid-frame: the frame completes, nothing follows.
        gap_chk = 1'b0;
        load(1, 4, 4, 1);
        h0 = hs_cnt;
        n  = 0;
        while (hs_cnt == h0 && n < 20) begin
            step();
            n++;
        end
        en = 1'b0;
        drain("en_drop", 100, 2);
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("en_drop_valid", out_req.tvalid, 0);
            chk("en_drop_busy", busy, 0);
        end
        chk("en_drop_held", src_q[0].size() + src_q[1].size(), 4);
        en = 1'b1;
        model_arb(1);
        drain("en_drop_resume", 100, 4);
        chk("en_fcnt", fcnt, frames_exp);

        // Reset asserted on the second beat of a frame.
        sb_off = 1'b1;
        gen_frame(0, 4);
        drive_inputs();
        h0 = hs_cnt;
        n  = 0;
        while (hs_cnt == h0 && n < 20) begin
            step();
            n++;
        end
        chk("rst_mid_beat_seen", hs_cnt - h0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int s = 0; s < NUM; s++) begin
            src_q[s].delete();
            m_q[s].delete();
            bub[s] = 0;
        end
        exp_q.delete();
        model_rr   = 0;
        frames_exp = 0;
        drive_inputs();
        #1;
        chk("rst_mid_valid", out_req.tvalid, 0);
        chk("rst_mid_tready", in_rsp[0].tready | in_rsp[1].tready, 0);
        chk("rst_mid_fcnt", fcnt, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant, 0);
        sb_off = 1'b0;
        load(1, 2, 2, NUM);
        drain("after_rst", 100, 4);
        chk("after_rst_fcnt", fcnt, frames_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet TX AXI-Stream path (the input of the width downsizer feeding the framing core) between NumIn requesters.
- Requesters are, for example, the DMA TX queue and the control/ARP responder.
- Arbitration is packet-granular round-robin: a grant is held until the tlast beat handshakes, so frames never interleave.
- Enforces a runtime-configurable idle gap between frames and counts forwarded frames for the register file.

Parameters:
- NumIn, 2, number of requesting AXI-Stream inputs (2..8).
- axi_stream_req_t, framing_synth_pkg::s_req_t, AXIS request struct (tdata/tstrb/tkeep/tlast/tid/tdest/tuser/tvalid); same type on all inputs and the output.
- axi_stream_rsp_t, framing_synth_pkg::s_rsp_t, AXIS response struct (tready).
- GapWidth, 8, width of the gap-cycle configuration.
- CntWidth, 32, width of the frame counter.

Ports:
- clk_i  in  1  single clock; the 125 MHz TX-domain clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_req_i  in  NumIn x axi_stream_req_t  requester streams.
- in_rsp_o  out  NumIn x axi_stream_rsp_t  requester tready.
- out_req_o  out  axi_stream_req_t  arbitrated stream to the downsizer.
- out_rsp_i  in  axi_stream_rsp_t  downstream tready.
- en_i  in  1  arbitration enable; when low, no new grant is issued.
- gap_cycles_i  in  GapWidth  idle cycles inserted after each frame's tlast.
- busy_o  out  1  high in STREAM or GAP.
- grant_o  out  $clog2(NumIn)  index of the current or most recent grant.
- frame_cnt_o  out  CntWidth  frames forwarded, wraps modulo 2^CntWidth.

Behaviour:
- FSM states: IDLE, STREAM, GAP.
- Registers: state, grant index gnt_q, round-robin pointer rr_q, gap counter, frame counter.
- Reset (rst_i high at a clk_i edge), applied in any state including mid-frame:
  - state=IDLE, gnt_q=0, rr_q=0, gap counter=0, frame_cnt_o=0.
  - out_req_o all fields 0, every in_rsp_o.tready=0, busy_o=0, grant_o=0.
  - A partially forwarded frame is abandoned; no tlast is synthesized.
- IDLE:
  - out tvalid=0; all input tready=0.
  - If en_i=1 and any in tvalid=1: select the first valid index searching rr_q, rr_q+1, ... modulo NumIn. Register it into gnt_q and go to STREAM.
  - Selection is combinational in IDLE; the first beat can appear on the output the following cycle, so minimum grant latency is 1 cycle.
- STREAM:
  - out_req_o = in_req_i[gnt_q], passed through combinationally (zero added latency per beat).
  - in_rsp_o[gnt_q].tready = out_rsp_i.tready; all other tready=0.
  - Source tvalid low: output tvalid low, hold the grant (stall, no timeout).
  - On out tvalid & tready & tlast:
    - frame_cnt_o += 1 next cycle.
    - rr_q = (gnt_q+1) mod NumIn.
    - If gap_cycles_i=0, go to IDLE; otherwise load the counter with gap_cycles_i and go to GAP.
  - en_i falling during STREAM does not truncate the frame.
- GAP:
  - out tvalid=0; all tready=0.
  - Counter decrements each cycle; at 1, go to IDLE.
  - Gives exactly gap_cycles_i idle cycles after the tlast cycle, plus the one IDLE arbitration cycle.
  - gap_cycles_i is sampled only at the tlast handshake; changes during GAP are ignored.
- Non-granted inputs never see tready=1. Their tvalid/data remain stable per AXIS rules and are not dropped.
- Single-beat frame (tvalid & tlast on the first beat): legal, STREAM lasts 1 cycle when tready=1.
- Simultaneous requests: resolved only by rr_q order. A requester waits at most NumIn-1 frames.
- grant_o = gnt_q; it holds its value through GAP and IDLE.
- Frame counter at all-ones wraps to 0.

Test Plan:
- Reset, then single requester, NumIn=2, gap=0: in[0] sends 3 beats (tlast on beat 3), out tready=1 -> out carries the beats on cycles 2..4 after request, frame_cnt_o=1, grant_o=0, in_rsp_o[1].tready never 1.
- Both inputs continuously valid with 2-beat frames, gap=0 -> output order in0, in1, in0, in1; no beat interleaving; one IDLE cycle between frames; frame_cnt_o=4 after 4 frames.
- gap_cycles_i=12 -> exactly 12 cycles of tvalid=0 in GAP after tlast, plus 1 IDLE cycle, before the next frame's first beat.
- Backpressure: out tready toggles 1010... during a 4-beat frame; source tvalid deasserted for 3 cycles mid-frame -> the 4 beats arrive in order unduplicated, the grant is held, and no other requester gets tready.
- en_i low with both valid -> no grant, busy_o=0. en_i dropped mid-frame -> the frame completes and no new grant follows. en_i=1 -> arbitration resumes at rr_q.
- rst_i asserted mid-STREAM on beat 2 -> next cycle out tvalid=0, all tready=0, frame_cnt_o=0, state IDLE. After release, in[0] wins (rr_q=0) when both are valid.
